rotary_decoder: RTL

Front-end stage of the rotary-encoder path: synchronises and debounces the raw quadrature (A/B) and push-button pins, tracks the quadrature phase, and emits one-cycle `rotl`/`rotr`/`push` event pulses per mechanical detent and per button press. Its outputs drive the `rotl`, `rotr` and `push` inputs of the downstream `rotaryQueue` directly. It also flags illegal quadrature jumps.

---
 rtl/rotary_pkg.sv | 42 ++++
 rtl/rotary_decoder_if.sv | 15 +
 rtl/rotary_debounce.sv | 54 +++++
 rtl/rotary_decoder.sv | 89 ++++++++
 4 files changed

// File: rtl/rotary_pkg.sv
// Shared types and constants for the rotary-encoder front end.
// Latency: n/a (declarations only).
// Backpressure: n/a; every consumer is a free-running pulse sink.
package rotary_pkg;

    // Quadrature phase, encoded as the debounced {a,b} pin pair.
    typedef logic [1:0] quad_t;
    localparam quad_t Q11 = 2'b11;
    localparam quad_t Q01 = 2'b01;
    localparam quad_t Q00 = 2'b00;
    localparam quad_t Q10 = 2'b10;

    localparam quad_t DETENT = 2'b11;

    localparam int ACC_W               = 4;
    localparam int FULL_STEP           = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 16;

    typedef logic signed [ACC_W-1:0] acc_t;
    localparam acc_t ACC_FULL = acc_t'(FULL_STEP);
    localparam acc_t ACC_ONE  = acc_t'(1);

    // Clockwise order 11 -> 01 -> 00 -> 10 -> 11.
    function automatic quad_t cw_next(input quad_t q);
        case (q)
            Q11:     cw_next = Q01;
            Q01:     cw_next = Q00;
            Q00:     cw_next = Q10;
            default: cw_next = Q11;
        endcase
    endfunction

    function automatic quad_t ccw_next(input quad_t q);
        case (q)
            Q11:     ccw_next = Q10;
            Q10:     ccw_next = Q00;
            Q00:     ccw_next = Q01;
            default: ccw_next = Q11;
        endcase
    endfunction

endpackage

// File: rtl/rotary_decoder_if.sv
// Raw encoder pins in, one-cycle event pulses out.
// Latency: n/a (wiring only).
// Backpressure: none; pulses are fire-and-forget into the downstream queue.
interface rotary_decoder_if;
    logic rot_a;
    logic rot_b;
    logic btn;
    logic rotl;
    logic rotr;
    logic push;
    logic err;

    modport master (output rot_a, rot_b, btn, input rotl, rotr, push, err);
    modport slave  (input rot_a, rot_b, btn, output rotl, rotr, push, err);
endinterface

// File: rtl/rotary_debounce.sv
// One-bit 2-flop synchroniser plus optional debounce filter (ROTARY_DEBOUNCE_EN).
// Latency: 2 cycles sync, plus CYCLES cycles when debounce is built in.
// Backpressure: none; output simply follows the filtered pin level.
module rotary_debounce
    import rotary_pkg::*;
#(
    parameter int   CYCLES  = DEBOUNCE_CYCLES_DEF,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic dout
);

    if (CYCLES < 2) begin : g_cycles_check
        $error("rotary_debounce: CYCLES must be at least 2");
    end

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) sync_q <= {2{RST_VAL}};
        else      sync_q <= {sync_q[0], din};
    end

`ifdef ROTARY_DEBOUNCE_EN
    localparam int               CNT_W    = $clog2(CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             deb_q;

    // Any sample that agrees with the current level restarts the count.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
            deb_q <= RST_VAL;
        end else if (sync_q[1] == deb_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            deb_q <= sync_q[1];
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign dout = deb_q;
`else
    assign dout = sync_q[1];
`endif

endmodule

// File: rtl/rotary_decoder.sv
// Rotary encoder front end: sync/debounce (ROTARY_DEBOUNCE_EN), quadrature decode, event pulses.
// Latency: 3 cycles pin-to-pulse, DEBOUNCE_CYCLES+3 with debounce enabled.
// Backpressure: none; rotl/rotr/push/err are single-cycle registered pulses.
module rotary_decoder
    import rotary_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             clr,
    rotary_decoder_if.slave  io
);

    logic a_d;
    logic b_d;
    logic btn_d;

    rotary_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_deb_a (
        .clk(clk), .clr(clr), .din(io.rot_a), .dout(a_d)
    );
    rotary_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_deb_b (
        .clk(clk), .clr(clr), .din(io.rot_b), .dout(b_d)
    );
    rotary_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_deb_btn (
        .clk(clk), .clr(clr), .din(io.btn), .dout(btn_d)
    );

    quad_t ab;
    quad_t st_q;
    quad_t st_nxt;
    acc_t  acc_q;
    acc_t  acc_nxt;
    acc_t  acc_step;
    logic  rotl_nxt;
    logic  rotr_nxt;
    logic  err_nxt;
    logic  btn_prev_q;

    assign ab = {a_d, b_d};

    always_comb begin
        st_nxt   = st_q;
        acc_nxt  = acc_q;
        acc_step = acc_q;
        rotl_nxt = 1'b0;
        rotr_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (ab != st_q) begin
            st_nxt = ab;
            if (ab == cw_next(st_q))
                acc_step = (acc_q == ACC_FULL) ? acc_q : acc_q + ACC_ONE;
            else if (ab == ccw_next(st_q))
                acc_step = (acc_q == -ACC_FULL) ? acc_q : acc_q - ACC_ONE;

            // A two-bit jump has no direction: flag it and drop the partial turn.
            if ((ab ^ st_q) == 2'b11) begin
                err_nxt = 1'b1;
                acc_nxt = '0;
            end else if (ab == DETENT) begin
                rotr_nxt = (acc_step == ACC_FULL);
                rotl_nxt = (acc_step == -ACC_FULL);
                acc_nxt  = '0;
            end else begin
                acc_nxt = acc_step;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            st_q       <= Q11;
            acc_q      <= '0;
            btn_prev_q <= 1'b0;
            io.rotl    <= 1'b0;
            io.rotr    <= 1'b0;
            io.push    <= 1'b0;
            io.err     <= 1'b0;
        end else begin
            st_q       <= st_nxt;
            acc_q      <= acc_nxt;
            btn_prev_q <= btn_d;
            io.rotl    <= rotl_nxt;
            io.rotr    <= rotr_nxt;
            io.push    <= btn_d & ~btn_prev_q;
            io.err     <= err_nxt;
        end
    end

endmodule
